vga_stream_out: RTL



---
 rtl/vga_stream_out.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_stream_out.sv
// VGA output stage: Avalon-ST RGB sink into a small pixel FIFO, 640x480@60 timing, registered DAC pins.
// Define VGA_TEST_PATTERN_EN to add the pattern_sel input and the 8-bar colour pattern generator.
module vga_stream_out #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    input  logic [23:0] st_data,
    input  logic        st_sop,
    input  logic        st_eop,
    input  logic        st_valid,
    output logic        st_ready,
    output logic [7:0]  vga_R,
    output logic [7:0]  vga_G,
    output logic [7:0]  vga_B,
    output logic        vga_HS,
    output logic        vga_VS,
    output logic        vga_BLANK,
    output logic        vga_SYNC,
    output logic [15:0] underflow_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_SEEK, ST_WAIT, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [24:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic [15:0]   uf_q, uf_d;
    logic [23:0]   pix_q, pix_d;
    logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic          push, pop, empty, active, at_origin, frame_end;
    logic [24:0]   head;
    logic          unused_eop;

    assign unused_eop = st_eop;
    assign head       = fifo_mem[rd_ptr_q];
    assign empty      = (count_q == '0);
    assign push       = st_valid && ready_q;
    assign active     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign at_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign frame_end  = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic          pat_q;
    logic [HW-1:0] bar_pos;
    logic [2:0]    bar;
    assign bar_pos = h_cnt_q / HW'(BAR_W);
    assign bar     = (bar_pos > HW'(7)) ? 3'd7 : bar_pos[2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pat_q <= 1'b0;
        else          pat_q <= pattern_sel;
    end
`endif

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
        hs_d    = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vs_d    = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        blank_d = active;
    end

    // Frame lock: SEEK drops beats until a SOP heads the FIFO, WAIT holds it until the counter wraps.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        pix_d   = '0;
        uf_d    = uf_q;
        unique case (state_q)
            ST_SEEK: begin
                if (!empty) begin
                    if (head[24]) state_d = ST_WAIT;
                    else          pop     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (frame_end) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (active) begin
                    if (empty) begin
                        state_d = ST_SEEK;
                        if (uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
                    end else if (at_origin && !head[24]) begin
                        state_d = ST_SEEK;
                    end else if (!at_origin && head[24]) begin
                        state_d = ST_WAIT;
                    end else begin
                        pop   = 1'b1;
                        pix_d = head[23:0];
                    end
                end
            end
            default: state_d = ST_SEEK;
        endcase
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_sel) begin
            state_d = state_q;
            pop     = 1'b0;
            uf_d    = uf_q;
            pix_d   = active ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : 24'h0;
        end else if (pat_q) begin
            state_d = ST_SEEK;
            pop     = 1'b0;
            uf_d    = uf_q;
            pix_d   = '0;
        end
`endif
    end

    // Ready is derived from the next occupancy so a full FIFO never sees a push.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ready_d  = (count_d != FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {st_sop, st_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_SEEK;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            uf_q     <= '0;
            pix_q    <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            blank_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            uf_q     <= uf_d;
            pix_q    <= pix_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            blank_q  <= blank_d;
        end
    end

    assign st_ready      = ready_q;
    assign vga_R         = pix_q[23:16];
    assign vga_G         = pix_q[15:8];
    assign vga_B         = pix_q[7:0];
    assign vga_HS        = hs_q;
    assign vga_VS        = vs_q;
    assign vga_BLANK     = blank_q;
    assign vga_SYNC      = 1'b0;
    assign underflow_cnt = uf_q;

endmodule
